// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage datapath (master) and hazard_ctrl (slave).
// Carries stage register indices/control bits in and stall/flush/forward controls out.
interface hazard_ctrl_if;
  logic [4:0] D_Rs1, D_Rs2;
  logic [4:0] E_Rs1, E_Rs2, E_Rd;
  logic [1:0] E_ResultSrc;
  logic       E_PCSrc, E_MulOp, E_DivOp;
  logic [4:0] M_Rd, W_Rd;
  logic       M_RegWrite, W_RegWrite;
  logic       F_Stall, D_Stall, D_Flush, E_Stall, E_Flush, M_Flush;
  logic [1:0] E_ForwardA, E_ForwardB;
  logic       mdu_start, mdu_busy;

  modport master (
    output D_Rs1, D_Rs2, E_Rs1, E_Rs2, E_Rd, E_ResultSrc, E_PCSrc, E_MulOp, E_DivOp,
           M_Rd, W_Rd, M_RegWrite, W_RegWrite,
    input  F_Stall, D_Stall, D_Flush, E_Stall, E_Flush, M_Flush, E_ForwardA, E_ForwardB,
           mdu_start, mdu_busy
  );

  modport slave (
    input  D_Rs1, D_Rs2, E_Rs1, E_Rs2, E_Rd, E_ResultSrc, E_PCSrc, E_MulOp, E_DivOp,
           M_Rd, W_Rd, M_RegWrite, W_RegWrite,
    output F_Stall, D_Stall, D_Flush, E_Stall, E_Flush, M_Flush, E_ForwardA, E_ForwardB,
           mdu_start, mdu_busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage RV32 pipeline, including the
// multi-cycle MUL/DIV sequencer that holds ID/EX and bubbles EX/MEM while the MDU works.
module hazard_ctrl #(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam bit             MUL_MULTI = (MUL_CYCLES > 1);
  localparam bit             DIV_MULTI = (DIV_CYCLES > 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_MULTI ? MUL_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_MULTI ? DIV_CYCLES - 2 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             load_use, mdu_req, mdu_multi;
  logic [CNT_W-1:0] mdu_load;
  logic             stall, f_stall, d_stall, d_flush, e_flush, m_flush, start, busy;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (rs != 5'd0 && hz.M_RegWrite && hz.M_Rd == rs)      return 2'b10;
    else if (rs != 5'd0 && hz.W_RegWrite && hz.W_Rd == rs) return 2'b01;
    else                                                   return 2'b00;
  endfunction

  assign load_use  = (hz.E_ResultSrc == 2'b01) && (hz.E_Rd != 5'd0) &&
                     ((hz.E_Rd == hz.D_Rs1) || (hz.E_Rd == hz.D_Rs2));
  assign mdu_req   = hz.E_MulOp | hz.E_DivOp;
  assign mdu_multi = hz.E_DivOp ? DIV_MULTI : MUL_MULTI;
  assign mdu_load  = hz.E_DivOp ? DIV_LOAD  : MUL_LOAD;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    f_stall = 1'b0;
    d_stall = 1'b0;
    d_flush = 1'b0;
    e_flush = 1'b0;
    m_flush = 1'b0;
    start   = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        // An MDU op in EX excludes load/branch there, so hazard detection only runs otherwise;
        // this also guarantees E_Flush is never raised in the accept cycle.
        if (mdu_req) begin
          start = 1'b1;
          if (mdu_multi) begin
            stall   = 1'b1;
            m_flush = 1'b1;
            cnt_d   = mdu_load;
            state_d = BUSY;
          end
        end else if (hz.E_PCSrc) begin
          d_flush = 1'b1;
          e_flush = 1'b1;
        end else if (load_use) begin
          f_stall = 1'b1;
          d_stall = 1'b1;
          e_flush = 1'b1;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (cnt_q != '0) begin
          stall   = 1'b1;
          m_flush = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are gated by rst so stalls drop in the same cycle reset is raised.
  assign hz.F_Stall    = !rst && (f_stall | stall);
  assign hz.D_Stall    = !rst && (d_stall | stall);
  assign hz.D_Flush    = !rst && d_flush;
  assign hz.E_Stall    = !rst && stall;
  assign hz.E_Flush    = !rst && e_flush;
  assign hz.M_Flush    = !rst && m_flush;
  assign hz.mdu_start  = !rst && start;
  assign hz.mdu_busy   = !rst && busy;
  assign hz.E_ForwardA = rst ? 2'b00 : fwd_sel(hz.E_Rs1);
  assign hz.E_ForwardB = rst ? 2'b00 : fwd_sel(hz.E_Rs2);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch flush, MDU sequencing,
// reset mid-op, plus a MUL_CYCLES=1 build.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if b0 ();
  hazard_ctrl_if b1 ();

  hazard_ctrl #(.MUL_CYCLES(3), .DIV_CYCLES(32), .CNT_W(6)) u_dut (
    .clk(clk), .rst(rst), .hz(b0)
  );
  hazard_ctrl #(.MUL_CYCLES(1), .DIV_CYCLES(32), .CNT_W(6)) u_dut1 (
    .clk(clk), .rst(rst), .hz(b1)
  );

  // {F_Stall, D_Stall, D_Flush, E_Stall, E_Flush, M_Flush, mdu_start, mdu_busy}
  function automatic logic [7:0] ctl0();
    return {b0.F_Stall, b0.D_Stall, b0.D_Flush, b0.E_Stall,
            b0.E_Flush, b0.M_Flush, b0.mdu_start, b0.mdu_busy};
  endfunction
  function automatic logic [7:0] ctl1();
    return {b1.F_Stall, b1.D_Stall, b1.D_Flush, b1.E_Stall,
            b1.E_Flush, b1.M_Flush, b1.mdu_start, b1.mdu_busy};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    b0.D_Rs1 = 0; b0.D_Rs2 = 0; b0.E_Rs1 = 0; b0.E_Rs2 = 0; b0.E_Rd = 0;
    b0.E_ResultSrc = 0; b0.E_PCSrc = 0; b0.E_MulOp = 0; b0.E_DivOp = 0;
    b0.M_Rd = 0; b0.W_Rd = 0; b0.M_RegWrite = 0; b0.W_RegWrite = 0;
    b1.D_Rs1 = 0; b1.D_Rs2 = 0; b1.E_Rs1 = 0; b1.E_Rs2 = 0; b1.E_Rd = 0;
    b1.E_ResultSrc = 0; b1.E_PCSrc = 0; b1.E_MulOp = 0; b1.E_DivOp = 0;
    b1.M_Rd = 0; b1.W_Rd = 0; b1.M_RegWrite = 0; b1.W_RegWrite = 0;
  endtask

  // Walks an n-cycle op through EX on b0; returns one edge after release.
  task automatic mdu_seq(input int n, input string tag);
    logic [7:0] exp;
    for (int i = 0; i < n; i++) begin
      #1;
      if (i == 0)          exp = 8'b1101_0110;
      else if (i < n - 1)  exp = 8'b1101_0101;
      else                 exp = 8'b0000_0001;
      check($sformatf("%s_cyc%0d", tag, i), ctl0(), exp);
      tick();
    end
  endtask

  initial begin
    clr();
    rst = 1'b1;
    // Reset: hazard-inducing inputs present, yet everything must stay 0.
    b0.E_PCSrc = 1; b0.M_RegWrite = 1; b0.M_Rd = 7; b0.E_Rs1 = 7; b0.E_DivOp = 1;
    #1;
    check("rst_ctl", ctl0(), 8'h00);
    check("rst_fwd", {4'b0, b0.E_ForwardA, b0.E_ForwardB}, 8'h00);
    tick(); tick();
    check("rst_ctl_held", ctl0(), 8'h00);
    rst = 1'b0;
    clr();
    tick();

    // 1. forwarding
    b0.M_RegWrite = 1; b0.M_Rd = 5; b0.W_RegWrite = 1; b0.W_Rd = 0; b0.E_Rs1 = 5; b0.E_Rs2 = 0;
    #1;
    check("fwd_mem", {6'b0, b0.E_ForwardA}, 8'd2);
    check("fwd_x0", {6'b0, b0.E_ForwardB}, 8'd0);
    b0.W_Rd = 5; #1;
    check("fwd_mem_beats_wb", {6'b0, b0.E_ForwardA}, 8'd2);
    b0.M_RegWrite = 0; b0.E_Rs2 = 5; #1;
    check("fwd_wb_a", {6'b0, b0.E_ForwardA}, 8'd1);
    check("fwd_wb_b", {6'b0, b0.E_ForwardB}, 8'd1);
    b0.M_RegWrite = 1; b0.M_Rd = 0; b0.W_RegWrite = 1; b0.W_Rd = 0; b0.E_Rs1 = 0; #1;
    check("fwd_x0_both", {6'b0, b0.E_ForwardA}, 8'd0);
    b0.M_Rd = 9; b0.E_Rs1 = 9; b0.E_Rs2 = 4; b0.W_Rd = 4; b0.W_RegWrite = 0; #1;
    check("fwd_split", {4'b0, b0.E_ForwardA, b0.E_ForwardB}, 8'b0000_1000);
    clr();

    // 2. load-use
    b0.E_ResultSrc = 2'b01; b0.E_Rd = 3; b0.D_Rs2 = 3; #1;
    check("lu_rs2", ctl0(), 8'b1100_1000);
    tick();
    b0.E_ResultSrc = 2'b00; b0.E_Rd = 0; b0.D_Rs2 = 0; #1;
    check("lu_bubble_done", ctl0(), 8'h00);
    b0.E_ResultSrc = 2'b01; b0.E_Rd = 3; b0.D_Rs1 = 3; #1;
    check("lu_rs1", ctl0(), 8'b1100_1000);
    b0.D_Rs1 = 0; b0.D_Rs2 = 0; #1;
    check("lu_nodep", ctl0(), 8'h00);
    b0.E_Rd = 0; #1;
    check("lu_x0", ctl0(), 8'h00);
    b0.E_ResultSrc = 2'b00; b0.E_Rd = 3; b0.D_Rs1 = 3; #1;
    check("lu_not_load", ctl0(), 8'h00);

    // 3. branch flush wins over load-use
    b0.E_ResultSrc = 2'b01; b0.E_PCSrc = 1; #1;
    check("br_over_lu", ctl0(), 8'b0010_1000);
    clr();
    tick();

    // 4. div then mul back-to-back
    b0.E_DivOp = 1;
    mdu_seq(32, "div");
    b0.E_DivOp = 0; b0.E_MulOp = 1;
    mdu_seq(3, "mul_b2b");
    b0.E_MulOp = 0; #1;
    check("mdu_idle_after", ctl0(), 8'h00);

    // 5. reset mid-div
    b0.E_DivOp = 1;
    for (int i = 0; i < 10; i++) tick();
    #1;
    check("div_mid_busy", ctl0(), 8'b1101_0101);
    rst = 1'b1; #1;
    check("div_rst_same_cyc", ctl0(), 8'h00);
    tick();
    rst = 1'b0; b0.E_DivOp = 0; #1;
    check("div_rst_idle", ctl0(), 8'h00);
    b0.E_DivOp = 1;
    mdu_seq(32, "div_restart");
    b0.E_DivOp = 0;

    // 6. single-cycle mul build
    b1.E_MulOp = 1; #1;
    check("mul1_accept", ctl1(), 8'b0000_0010);
    tick();
    check("mul1_next", ctl1(), 8'b0000_0010);
    b1.E_MulOp = 0; #1;
    check("mul1_idle", ctl1(), 8'h00);
    b1.E_DivOp = 1; #1;
    check("mul1_build_div", ctl1(), 8'b1101_0110);
    b1.E_DivOp = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
